// File: rtl/nibble_pkg.sv
// Shared types and sizing constants for the nibble unpacker.
package nibble_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 16;
    localparam int NIBS   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/nibble_sel.sv
// Combinational 4:1 nibble selector over a 16-bit word.
module nibble_sel
    import nibble_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        index,
    output logic [NIB_W-1:0]  nibble
);

    // Pick nibble number `index` out of the word
    always_comb begin
        nibble = 4'h0;
        case (index)
            2'd0:    nibble = word[3:0];
            2'd1:    nibble = word[7:4];
            2'd2:    nibble = word[11:8];
            2'd3:    nibble = word[15:12];
            default: nibble = 4'h0;
        endcase
    end

endmodule

// File: rtl/nibble_unpacker.sv
// Splits a latched 16-bit word into 1..4 nibbles on a valid/ready stream,
// accepting the next word on the same edge as the final nibble handshake.
module nibble_unpacker
    import nibble_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [1:0]        in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       words_done
);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        len_q, len_d;
    logic [15:0]       words_done_q, words_done_d;

    logic              accept_s;
    logic              nib_hs_s;
    logic [1:0]        last_idx_s;

    nibble_sel u_sel (
        .word   (word_q),
        .index  (idx_q),
        .nibble (out_data)
    );

    assign last_idx_s = LSB_FIRST ? len_q : 2'd0;
    assign out_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    // Gated by state so the idle/reset value of out_last is 0 even when idx == len
    assign out_last   = (state_q == SEND) && (idx_q == last_idx_s);
    assign nib_hs_s   = out_valid & out_ready;
    assign in_ready   = Rst_n & ((state_q == IDLE) | (nib_hs_s & out_last));
    assign accept_s   = in_valid & in_ready;
    assign words_done = words_done_q;

    // Next-state: advance the index on a handshake, reload on acceptance
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        if (nib_hs_s) begin
            if (out_last) begin
                state_d      = IDLE;
                words_done_d = words_done_q + 16'd1;
            end else begin
                idx_d = LSB_FIRST ? (idx_q + 2'd1) : (idx_q - 2'd1);
            end
        end else begin
            idx_d = idx_q;
        end
        // A same-edge acceptance overrides the return to IDLE
        if (accept_s) begin
            state_d = SEND;
            word_d  = in_data;
            len_d   = in_len;
            idx_d   = LSB_FIRST ? 2'd0 : in_len;
        end else begin
            word_d = word_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            word_q       <= 16'h0000;
            len_q        <= 2'd0;
            words_done_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
        end
    end

endmodule
